// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage of the multi-cycle MIPS core. Owns the PC and requests one
//   instruction word per fetch over a req/ack handshake with instruction
//   memory. It holds that word for control decode and execute, and picks the
//   next PC once execute signals advance. There are no delay slots.
//
// Parameters
//   RESET_PC      PC loaded on reset
//   TIMEOUT       WAIT cycles tolerated without imem_ack (>= 1)
//
// Ports
//   clk, rst_b    core clock; synchronous active-low reset
//   imem_req      one-cycle fetch request strobe (REQ state)
//   imem_addr     fetch address (current pc), stable from req until ack
//   imem_ack      imem_rdata valid this cycle (honoured only in WAIT)
//   imem_rdata    instruction word from memory
//   inst          held instruction; opcode/func are its decode fields
//   pc            address of inst
//   inst_valid    inst/opcode/func valid for decode (VALID state)
//   advance       execute done; Jump/JumpReg/Branch/alu_zero/rs_data valid
//   Halted        decode saw an unsupported instruction
//   fetch_halted  fetch stopped; left only by reset
//   fetch_err     stop was caused by timeout or a misaligned target
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic [31:0] pc,
  output logic        inst_valid,
  input  logic        advance,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic        Branch,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  input  logic        Halted,
  output logic        fetch_halted,
  output logic        fetch_err
);

  // The counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [31:0]       pc4;
  logic [31:0]       br_off;
  logic [31:0]       next_pc;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-PC selection; Jump with JumpReg is JR and takes priority over both
  // the pseudo-direct jump and a taken branch. All adds wrap mod 2^32.
  always_comb begin
    pc4    = pc_q + 32'd4;
    br_off = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
    if (Jump && JumpReg) begin
      next_pc = rs_data;
    end else if (Jump) begin
      next_pc = {pc4[31:28], inst_q[25:0], 2'b00};
    end else if (Branch && alu_zero) begin
      next_pc = pc4 + br_off;
    end else begin
      next_pc = pc4;
    end
  end

  // Fetch FSM. The wait counter only runs in WAIT and is zero elsewhere,
  // so leaving WAIT by any path clears it. A misaligned target halts the
  // fetch with pc left pointing at the instruction that produced it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = '0;
    err_d   = err_q;
    unique case (state_q)
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = S_VALID;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_VALID: begin
        if (Halted) begin
          state_d = S_HALT;
        end else if (advance) begin
          if (next_pc[1:0] != 2'b00) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // imem_req is gated by rst_b so no strobe is seen while reset is held,
  // even though the state register already sits in REQ.
  assign imem_req     = (state_q == S_REQ) && rst_b;
  assign imem_addr    = pc_q;
  assign inst         = inst_q;
  assign opcode       = inst_q[31:26];
  assign func         = inst_q[5:0];
  assign pc           = pc_q;
  assign inst_valid   = (state_q == S_VALID);
  assign fetch_halted = (state_q == S_HALT);
  assign fetch_err    = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Self-checking bench for instr_fetch_unit. A vector table covers the
//   next-PC selection rules, hand-written sequences cover reset, halt,
//   timeout, misaligned targets and reset during a fetch, and a randomized
//   run compares against a plain-arithmetic next-PC model.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [31:0] pc;
  logic        inst_valid;
  logic        advance;
  logic        Jump;
  logic        JumpReg;
  logic        Branch;
  logic        alu_zero;
  logic [31:0] rs_data;
  logic        Halted;
  logic        fetch_halted;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] startPc;
    logic [31:0] word;
    logic        j;
    logic        jr;
    logic        br;
    logic        z;
    logic [31:0] rs;
    logic [31:0] expNext;
  } vec_t;

  vec_t vecs[8];

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .opcode       (opcode),
    .func         (func),
    .pc           (pc),
    .inst_valid   (inst_valid),
    .advance      (advance),
    .Jump         (Jump),
    .JumpReg      (JumpReg),
    .Branch       (Branch),
    .alu_zero     (alu_zero),
    .rs_data      (rs_data),
    .Halted       (Halted),
    .fetch_halted (fetch_halted),
    .fetch_err    (fetch_err)
  );

  // Free-running clock; outputs are sampled and inputs driven on negedges.
  always #5 clk = ~clk;

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Next PC from the architectural rules, written as plain arithmetic.
  function automatic logic [31:0] refNext(input logic [31:0] curPc, input logic [31:0] word,
                                          input logic j, input logic jr, input logic br,
                                          input logic z, input logic [31:0] rs);
    logic [31:0]        seq;
    logic signed [15:0] imm;
    int                 off;
    seq = curPc + 32'd4;
    imm = word[15:0];
    off = imm;
    if (j && jr) return rs;
    if (j) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    if (br && z) return seq + 32'(off * 4);
    return seq;
  endfunction

  // Single comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Quiet all control inputs.
  task automatic clearInputs();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    advance    = 1'b0;
    Jump       = 1'b0;
    JumpReg    = 1'b0;
    Branch     = 1'b0;
    alu_zero   = 1'b0;
    rs_data    = 32'h0;
    Halted     = 1'b0;
  endtask

  // Hold reset across an edge, check reset state, release; leaves the
  // bench just after a negedge with the DUT in its first REQ cycle.
  task automatic doReset();
    rst_b = 1'b0;
    clearInputs();
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_req_low",  imem_req,     0);
    checkOutput("rst_pc",       pc,           32'h0);
    checkOutput("rst_addr",     imem_addr,    32'h0);
    checkOutput("rst_inst",     inst,         32'h0);
    checkOutput("rst_valid",    inst_valid,   0);
    checkOutput("rst_halted",   fetch_halted, 0);
    checkOutput("rst_err",      fetch_err,    0);
    rst_b = 1'b1;
    #1;
  endtask

  // From a REQ cycle: check the strobe, let memory answer after 'delay'
  // WAIT cycles, then check the held instruction. Ack in REQ and advance
  // outside VALID are driven as noise that must be ignored.
  task automatic serveFetch(input logic [31:0] expAddr, input logic [31:0] word, input int delay);
    checkOutput("req_strobe", imem_req,  1);
    checkOutput("req_addr",   imem_addr, expAddr);
    imem_ack   = 1'($urandom);
    imem_rdata = $urandom;
    advance    = 1'($urandom);
    Jump       = 1'($urandom);
    @(negedge clk);
    for (int i = 0; i < delay; i++) begin
      imem_ack = 1'b0;
      advance  = 1'($urandom);
      checkOutput("wait_req_low", imem_req,   0);
      checkOutput("wait_invalid", inst_valid, 0);
      @(negedge clk);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    clearInputs();
    checkOutput("fetch_valid", inst_valid, 1);
    checkOutput("fetch_inst",  inst,       word);
    checkOutput("fetch_pc",    pc,         expAddr);
  endtask

  // One VALID-cycle decision with the given decode/execute results.
  task automatic applyStimulus(input logic adv, input logic j, input logic jr, input logic br,
                               input logic z, input logic [31:0] rs, input logic halt);
    advance  = adv;
    Jump     = j;
    JumpReg  = jr;
    Branch   = br;
    alu_zero = z;
    rs_data  = rs;
    Halted   = halt;
    @(negedge clk);
    clearInputs();
  endtask

  initial begin
    logic [31:0] modelPc;
    logic [31:0] word;
    logic        j, jr, br, z;
    logic [31:0] rs;
    logic [31:0] nxt;

    vecs[0] = '{32'h0000_0010, 32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  32'h0000_000C};
    vecs[1] = '{32'h0000_0010, 32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0000_0014};
    vecs[2] = '{32'h4000_0010, 32'h0800_0100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h4000_0400};
    vecs[3] = '{32'h4000_0010, 32'h0800_0100, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0000_0080};
    vecs[4] = '{32'h4000_0010, 32'h0800_0100, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,  32'h4000_0400};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0000_0000};
    vecs[6] = '{32'h0000_0100, 32'h1000_0003, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,  32'h0000_0110};
    vecs[7] = '{32'h0000_0020, 32'h1000_0003, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0000_0024};

    rst_b = 1'b0;
    clearInputs();

    // Basic fetch: one-cycle ack, decode fields, stable hold, advance to pc+4.
    doReset();
    serveFetch(32'h0, 32'h2008_0005, 0);
    checkOutput("t1_opcode", opcode, 32'h08);
    checkOutput("t1_func",   func,   32'h05);
    for (int i = 0; i < 3; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      @(negedge clk);
      checkOutput("t1_hold_inst",  inst,       32'h2008_0005);
      checkOutput("t1_hold_valid", inst_valid, 1);
      checkOutput("t1_hold_noreq", imem_req,   0);
    end
    imem_ack = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("t1_next_req",  imem_req,  1);
    checkOutput("t1_next_addr", imem_addr, 32'h4);

    // Next-PC vector table; each vector first reaches its start PC by JR.
    for (int v = 0; v < 8; v++) begin
      doReset();
      serveFetch(32'h0, 32'h0, 0);
      applyStimulus(1, 1, 1, 0, 0, vecs[v].startPc, 0);
      serveFetch(vecs[v].startPc, vecs[v].word, v % TIMEOUT);
      checkOutput("vec_opcode", opcode, 32'(vecs[v].word[31:26]));
      checkOutput("vec_func",   func,   32'(vecs[v].word[5:0]));
      applyStimulus(1, vecs[v].j, vecs[v].jr, vecs[v].br, vecs[v].z, vecs[v].rs, 0);
      checkOutput("vec_req",       imem_req,  1);
      checkOutput("vec_next_addr", imem_addr, vecs[v].expNext);
    end

    // Halted wins over advance; fetch stays stopped until reset.
    doReset();
    serveFetch(32'h0, 32'hFC00_0000, 1);
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 1);
    checkOutput("t4_halted", fetch_halted, 1);
    checkOutput("t4_err",    fetch_err,    0);
    checkOutput("t4_valid",  inst_valid,   0);
    checkOutput("t4_pc",     pc,           32'h0);
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'($urandom);
      advance  = 1'b1;
      @(negedge clk);
      checkOutput("t4_stay_noreq",  imem_req,     0);
      checkOutput("t4_stay_halted", fetch_halted, 1);
    end
    clearInputs();

    // Timeout: TIMEOUT WAIT cycles without ack, then halt with error.
    doReset();
    checkOutput("t5_req", imem_req, 1);
    @(negedge clk);
    for (int i = 0; i < TIMEOUT; i++) begin
      checkOutput("t5_not_yet_halted", fetch_halted, 0);
      @(negedge clk);
    end
    checkOutput("t5_halted", fetch_halted, 1);
    checkOutput("t5_err",    fetch_err,    1);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    clearInputs();
    checkOutput("t5_late_ack_inst", inst,         32'h0);
    checkOutput("t5_late_ack_halt", fetch_halted, 1);
    checkOutput("t5_late_ack_req",  imem_req,     0);

    // Ack on the last permitted WAIT cycle still succeeds.
    doReset();
    serveFetch(32'h0, 32'h0000_0020, TIMEOUT - 1);
    checkOutput("t5_edge_halted", fetch_halted, 0);

    // Misaligned JR target halts with error, pc unchanged.
    doReset();
    serveFetch(32'h0, 32'h0080_0008, 0);
    applyStimulus(1, 1, 1, 0, 0, 32'h82, 0);
    checkOutput("t5_mis_halted", fetch_halted, 1);
    checkOutput("t5_mis_err",    fetch_err,    1);
    checkOutput("t5_mis_pc",     pc,           32'h0);
    checkOutput("t5_mis_req",    imem_req,     0);

    // Reset during WAIT discards the fetch and restarts at RESET_PC.
    doReset();
    serveFetch(32'h0, 32'h0000_0020, 0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("t6_addr4", imem_addr, 32'h4);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    checkOutput("t6_rst_pc",    pc,         32'h0);
    checkOutput("t6_rst_req",   imem_req,   0);
    checkOutput("t6_rst_valid", inst_valid, 0);
    rst_b = 1'b1;
    #1;
    serveFetch(32'h0, 32'h2008_0005, 0);

    // Randomized run against the reference next-PC model.
    doReset();
    modelPc = 32'h0;
    for (int n = 0; n < 40; n++) begin
      word = $urandom;
      serveFetch(modelPc, word, $urandom_range(0, TIMEOUT - 1));
      for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
        imem_ack   = 1'($urandom);
        imem_rdata = $urandom;
        Jump       = 1'($urandom);
        @(negedge clk);
        checkOutput("rnd_hold_inst", inst, word);
      end
      clearInputs();
      j   = 1'($urandom);
      jr  = 1'($urandom);
      br  = 1'($urandom);
      z   = 1'($urandom);
      rs  = $urandom & 32'hFFFF_FFFC;
      nxt = refNext(modelPc, word, j, jr, br, z, rs);
      applyStimulus(1, j, jr, br, z, rs, 0);
      modelPc = nxt;
    end
    checkOutput("rnd_final_addr", imem_addr, modelPc);
    checkOutput("rnd_final_req",  imem_req,  1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
